// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the instruction/data RAM arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;

  localparam int WORD_BYTES = 4;

  // An access is rejected when it is not word aligned or points past the last word.
  function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
    return (addr[1:0] != 2'b00) ||
           ((addr >> $clog2(WORD_BYTES)) >= 32'(depth_words));
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Fetch, data and RAM-side signals of the RAM arbiter grouped as one bus.
interface ram_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;

  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  // The arbiter itself.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_busy,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, ram_we, ram_addr, ram_wdata
  );

  // Requesters and RAM seen from the outside.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata, ram_busy,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram_arb_prio.sv
// Winner select between fetch and data; data has priority, bounded by a starvation counter.
module ram_arb_prio
  import ram_arb_pkg::*;
#(
  parameter int MAX_CONSEC = 4
) (
  input  logic    clk,
  input  logic    nRst,
  input  logic    i_req,
  input  logic    d_req,
  input  logic    arbitrate,
  output logic    grant_valid,
  output req_id_t grant_id
);

  localparam int CW = $clog2(MAX_CONSEC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CONSEC);

  logic [CW-1:0] consec_cnt;
  logic          starved;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    starved     = i_req && (consec_cnt == CNT_MAX);
    grant_valid = i_req || d_req;
    grant_id    = (d_req && !starved) ? REQ_D : REQ_I;
  end

  // Counts data grants that bypassed a waiting fetch; saturates at CNT_MAX.
  always_ff @(posedge clk) begin
    if (nRst) begin
      consec_cnt <= '0;
    end else if (arbitrate) begin
      if (!i_req || grant_id == REQ_I)
        consec_cnt <= '0;
      else if (consec_cnt != CNT_MAX)
        consec_cnt <= consec_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access via IDLE/ACCESS/RESP.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DEPTH_WORDS = 48,
  parameter int MAX_CONSEC  = 4
) (
  input  logic           clk,
  input  logic           nRst,
  ram_arbiter_if.slave   bus
);

  arb_state_t  state_q, state_d;
  req_id_t     lat_id;
  logic        lat_we;
  logic        lat_err;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;

  logic        arbitrate;
  logic        grant_valid;
  req_id_t     grant_id;
  logic [31:0] win_addr;
  logic        win_we;
  logic        win_err;

  assign arbitrate = (state_q == IDLE);

  ram_arb_prio #(.MAX_CONSEC(MAX_CONSEC)) u_prio (
    .clk         (clk),
    .nRst        (nRst),
    .i_req       (bus.i_req),
    .d_req       (bus.d_req),
    .arbitrate   (arbitrate),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    win_addr = (grant_id == REQ_D) ? bus.d_addr : bus.i_addr;
    win_we   = (grant_id == REQ_D) && bus.d_we;
    win_err  = addr_err(win_addr, DEPTH_WORDS);
  end

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q   <= IDLE;
      lat_id    <= REQ_I;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            lat_id    <= grant_id;
            lat_we    <= win_we;
            lat_err   <= win_err;
            lat_addr  <= win_addr;
            lat_wdata <= (grant_id == REQ_D) ? bus.d_wdata : '0;
            rdata_q   <= '0;
          end
        end
        ACCESS: begin
          // Writes and rejected accesses leave rdata at the zero loaded in IDLE.
          if (!bus.ram_busy && !lat_we)
            rdata_q <= bus.ram_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) state_d = win_err ? RESP : ACCESS;
      ACCESS:  if (!bus.ram_busy) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.i_ack     = 1'b0;
    bus.i_err     = 1'b0;
    bus.i_rdata   = '0;
    bus.d_ack     = 1'b0;
    bus.d_err     = 1'b0;
    bus.d_rdata   = '0;
    if (state_q == ACCESS) begin
      bus.ram_addr  = lat_addr;
      bus.ram_wdata = lat_wdata;
      // Gating with the reset input keeps a reset edge from committing a write.
      bus.ram_we    = lat_we && !bus.ram_busy && !nRst;
    end
    if (state_q == RESP) begin
      if (lat_id == REQ_D) begin
        bus.d_ack   = 1'b1;
        bus.d_err   = lat_err;
        bus.d_rdata = rdata_q;
      end else begin
        bus.i_ack   = 1'b1;
        bus.i_err   = lat_err;
        bus.i_rdata = rdata_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed requests push expected acks, a monitor checks them.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  typedef struct {
    req_id_t     id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic nRst;
  logic mem_load;
  int   errors;
  int   checks;
  int   we_cnt;
  exp_t sb[$];
  logic [31:0] mem [48];

  ram_arbiter_if bus ();

  ram_arbiter #(.DEPTH_WORDS(48), .MAX_CONSEC(4)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: combinational read, write on the clock edge.
  assign bus.ram_rdata = (bus.ram_addr[31:2] < 30'd48) ? mem[bus.ram_addr[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 48; k++) mem[k] <= 32'h0;
      mem[2]  <= 32'hDEAD_BEEF;
      mem[47] <= 32'h4747_4747;
      we_cnt  <= 0;
    end else if (bus.ram_we) begin
      if (bus.ram_addr[31:2] < 30'd48) mem[bus.ram_addr[7:2]] <= bus.ram_wdata;
      we_cnt <= we_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every ack and compares the response.
  always @(negedge clk) begin
    exp_t   e;
    req_id_t got_id;
    if (bus.ram_busy) check("we_while_busy", 32'(bus.ram_we), 32'h0);
    if (bus.i_ack || bus.d_ack) begin
      check("ack_exclusive", 32'(bus.i_ack && bus.d_ack), 32'h0);
      check("ack_expected", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        e      = sb.pop_front();
        got_id = bus.d_ack ? REQ_D : REQ_I;
        check("ack_id", 32'(got_id), 32'(e.id));
        check("ack_rdata", got_id == REQ_D ? bus.d_rdata : bus.i_rdata, e.rdata);
        check("ack_err", 32'(got_id == REQ_D ? bus.d_err : bus.i_err), 32'(e.err));
      end
    end
  end

  task automatic do_req(input req_id_t id, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input logic exp_err, input int exp_lat, input int busy,
                        input string name);
    int   n;
    logic got;
    int   b;
    @(posedge clk); #1;
    if (id == REQ_D) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    sb.push_back('{id: id, rdata: exp_rdata, err: exp_err});
    b = busy;
    if (b > 0) begin
      bus.ram_busy = 1'b1;
      fork
        begin
          repeat (b + 1) @(posedge clk);
          #1 bus.ram_busy = 1'b0;
        end
      join_none
    end
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (id == REQ_D ? bus.d_ack : bus.i_ack) got = 1'b1;
      else n++;
    end
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    @(posedge clk); #1;
    if (id == REQ_D) bus.d_req = 1'b0; else bus.i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0;
    int acks;
    int d_before_i;
    logic seen_i;
    int n;
    errors = 0; checks = 0;
    nRst = 1'b1; mem_load = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.ram_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {30'h0, bus.i_ack, bus.d_ack}, 32'h0);
    check("rst_ram_we", 32'(bus.ram_we), 32'h0);
    check("rst_ram_addr", bus.ram_addr, 32'h0);
    @(posedge clk); #1;
    nRst = 1'b0; mem_load = 1'b0;
    @(negedge clk);
    check("idle_outputs", {bus.i_rdata | bus.d_rdata | bus.ram_wdata}, 32'h0);

    // Single fetch of word 2.
    do_req(REQ_I, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, "fetch");

    // Write then read back.
    w0 = we_cnt;
    do_req(REQ_D, 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1'b0, 2, 0, "write");
    check("write_count", 32'(we_cnt - w0), 32'h1);
    check("write_mem", mem[4], 32'h1234_5678);
    do_req(REQ_D, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 1'b0, 2, 0, "read");

    // Write stalled by three busy cycles in ACCESS.
    w0 = we_cnt;
    do_req(REQ_D, 1'b1, 32'h14, 32'hA5A5_0001, 32'h0, 1'b0, 5, 3, "busy_write");
    check("busy_write_count", 32'(we_cnt - w0), 32'h1);
    check("busy_write_mem", mem[5], 32'hA5A5_0001);

    // Rejected accesses and the last legal word.
    w0 = we_cnt;
    do_req(REQ_D, 1'b1, 32'h06, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 0, "err_misaligned_write");
    check("err_write_count", 32'(we_cnt - w0), 32'h0);
    do_req(REQ_I, 1'b0, 32'hC0, 32'h0, 32'h0, 1'b1, 1, 0, "err_range_fetch");
    do_req(REQ_D, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, "err_misaligned_read");
    do_req(REQ_I, 1'b0, 32'hBC, 32'h0, 32'h4747_4747, 1'b0, 2, 0, "last_word_fetch");

    // Contention with both requesters held: D,D,D,D,I repeated.
    @(posedge clk); #1;
    bus.i_req = 1'b1; bus.i_addr = 32'h08;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) sb.push_back('{id: REQ_D, rdata: 32'h1234_5678, err: 1'b0});
      sb.push_back('{id: REQ_I, rdata: 32'hDEAD_BEEF, err: 1'b0});
    end
    acks = 0; n = 0; d_before_i = 0; seen_i = 1'b0;
    while (acks < 10 && n < 200) begin
      @(negedge clk);
      if (bus.i_ack) seen_i = 1'b1;
      if (bus.d_ack && !seen_i) d_before_i++;
      if (bus.i_ack || bus.d_ack) acks++;
      n++;
    end
    check("contention_acks", 32'(acks), 32'd10);
    check("data_acks_before_fetch", 32'(d_before_i), 32'd4);
    @(posedge clk); #1;
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    repeat (2) @(posedge clk);

    // Reset asserted during the ACCESS cycle of a write.
    w0 = we_cnt;
    @(posedge clk); #1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h18; bus.d_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check("mid_access_addr", bus.ram_addr, 32'h18);
    nRst = 1'b1; bus.d_req = 1'b0;
    @(negedge clk);
    check("mid_reset_we", 32'(bus.ram_we), 32'h0);
    @(posedge clk); #1;
    nRst = 1'b0;
    @(negedge clk);
    check("post_reset_acks", {30'h0, bus.i_ack, bus.d_ack}, 32'h0);
    check("post_reset_ram", bus.ram_addr | bus.ram_wdata | 32'(bus.ram_we), 32'h0);
    check("post_reset_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
    repeat (3) @(posedge clk);
    check("mid_reset_mem", mem[6], 32'h0);
    check("mid_reset_count", 32'(we_cnt - w0), 32'h0);

    // Normal operation resumes from IDLE.
    do_req(REQ_I, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, "fetch_after_reset");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-ported data/instruction RAM between two requesters: instruction fetch (read-only) and data memory (read/write).
- Sequences each access through a fixed IDLE/ACCESS/RESP handshake and honours the RAM's busy signal.
- Data port has priority; a starvation counter guarantees fetch progress.
- Out-of-range and misaligned accesses are rejected before they reach the RAM.

Parameters:
- DEPTH_WORDS, 48: number of 32-bit words in the RAM. Legal word index is 0..DEPTH_WORDS-1.
- MAX_CONSEC, 4: maximum consecutive data grants while fetch is waiting. Must be >= 1.

Ports:
- clk  in  1  system clock
- nRst  in  1  reset, synchronous, active-high (1 = reset)
- i_req  in  1  fetch request; held until i_ack
- i_addr  in  32  fetch byte address
- i_rdata  out  32  fetch read data; valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse for fetch
- i_err  out  1  valid with i_ack; address misaligned or out of range
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  write data
- d_rdata  out  32  read data; valid while d_ack=1 and d_we was 0
- d_ack  out  1  one-cycle completion pulse for data
- d_err  out  1  valid with d_ack
- ram_we  out  1  to RAM write_enable
- ram_addr  out  32  to RAM addr
- ram_wdata  out  32  to RAM data_in
- ram_rdata  in  32  from RAM data_out (combinational read)
- ram_busy  in  1  from RAM busy

Behaviour:
- Reset (nRst=1 at a clk edge):
  - state returns to IDLE; consec_cnt, latched request, rdata register and all acks/errs are cleared.
  - Any in-flight transaction is dropped, with no ack.
  - ram_we is combinationally gated by !nRst, so no RAM write occurs on a reset edge.
- FSM states IDLE, ACCESS, RESP:
  - IDLE:
    - If any request is pending, arbitrate, latch the winner (id, we, addr, wdata) and compute err.
    - Next state is ACCESS if err=0, otherwise RESP. If no request is pending, stay in IDLE.
  - ACCESS:
    - Drive ram_addr and ram_wdata from the latched request; ram_we = latched_we & !ram_busy.
    - If ram_busy=1, stay in ACCESS.
    - Otherwise capture ram_rdata into the rdata register at the edge and go to RESP.
  - RESP:
    - Assert the winner's ack for exactly one cycle, with rdata (0 on err or write) and err.
    - Next state is IDLE.
- Latency: a request seen in IDLE at cycle N with ram_busy=0 is acked in cycle N+2. Each busy cycle adds one cycle. An err access is acked at N+1.
- Requester rule: a requester must drop req in the cycle after its ack. req=1 in that cycle is treated as a new request.
- Outside ACCESS: ram_we=0, ram_addr=0, ram_wdata=0.
- Arbitration (IDLE only):
  - Only one request pending: it wins.
  - Both pending: data wins unless consec_cnt == MAX_CONSEC, in which case fetch wins.
  - consec_cnt increments (saturating) on each data grant made while i_req=1.
  - consec_cnt clears on a fetch grant, or on any arbitration where i_req=0.
  - consec_cnt width is $clog2(MAX_CONSEC+1).
- Error rules:
  - err = (addr[1:0] != 0) | ((addr>>2) >= DEPTH_WORDS).
  - Err writes never assert ram_we.
  - i_err/d_err are 0 whenever the matching ack is 0.
- Non-winners see ack=0 and keep waiting; a request is never lost while held.
- i_ack and d_ack are never high in the same cycle.

Decomposition:
- Package ram_arb_pkg:
  - state enum arb_state_t {IDLE, ACCESS, RESP}
  - requester enum req_id_t {REQ_I, REQ_D}
  - WORD_BYTES = 4
- Sub-module ram_arb_prio: combinational winner select plus the registered starvation counter.
  - Inputs: i_req, d_req, arbitrate strobe.
  - Outputs: grant_valid, grant_id.

Test Plan:
- Single fetch, ram_busy=0: i_req=1, i_addr=0x08 with RAM word 2 = 0xDEADBEEF -> i_ack=1 exactly two cycles later, i_rdata=0xDEADBEEF, i_err=0.
- Write then read: d_we=1, d_addr=0x10, d_wdata=0x12345678 -> ram_we high for exactly one cycle, d_ack. A following read of 0x10 -> d_rdata=0x12345678.
- Contention starvation, MAX_CONSEC=4: d_req and i_req held continuously -> grant order D,D,D,D,I,D,... The fetch ack arrives after the 4th data ack.
- Busy stall: ram_busy=1 for 3 cycles during ACCESS of a write -> ram_we stays 0 while busy, one write on the first non-busy edge, d_ack 5 cycles after the request.
- Errors: d_addr=0x06 write, and i_addr=0xC0 (word 48) -> ack after one cycle with err=1, rdata=0, ram_we never asserted.
- Reset mid-ACCESS: assert nRst during a write's ACCESS cycle -> no RAM write, no ack, state IDLE, all outputs 0 on the next cycle.
